// File: rtl/clk_tick_gen.sv
// clk_tick_gen: free-running count plus NUM_CH independent tick/clock-enable
// channels, each with a runtime-programmable period of N+1 enabled cycles.
// Each channel produces a registered 1-cycle tick and a square wave that
// toggles on every tick. Period changes on a running channel are deferred
// to its next terminal count, so the current period is never cut short.
module clk_tick_gen #(
  parameter int          WIDTH       = 30,
  parameter int          NUM_CH      = 4,
  parameter int unsigned DEFAULT_DIV = 0
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         en,
  input  logic                                         div_load,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] div_ch,
  input  logic [WIDTH-1:0]                             div_val,
  output logic                                         load_ack,
  output logic [WIDTH-1:0]                             free_cnt,
  output logic [NUM_CH-1:0]                            tick,
  output logic [NUM_CH-1:0]                            sq
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] DIV_INIT = WIDTH'(DEFAULT_DIV);

  // Per-channel state: active period, deferred period, down-counter.
  logic [WIDTH-1:0]  div_q    [NUM_CH];
  logic [WIDTH-1:0]  shadow_q [NUM_CH];
  logic [WIDTH-1:0]  cnt_q    [NUM_CH];
  logic [NUM_CH-1:0] pending_q;

  logic              ch_valid;
  logic [NUM_CH-1:0] ld_sel;

  // Decode the load strobe into a one-hot per-channel select.
  always_comb begin
    ch_valid = (32'(div_ch) < 32'(NUM_CH));
    ld_sel   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ld_sel[c] = div_load && ch_valid && (32'(div_ch) == c);
    end
  end

  // Free-running count and load acknowledge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      free_cnt <= '0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= div_load && ch_valid;
      if (en) begin
        free_cnt <= free_cnt + ONE;
      end
    end
  end

  // Channel down-counters, reload/apply logic, tick and square outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        div_q[c]    <= DIV_INIT;
        shadow_q[c] <= DIV_INIT;
        cnt_q[c]    <= DIV_INIT;
      end
      pending_q <= '0;
      tick      <= '0;
      sq        <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (div_q[c] == '0) begin
          // Disabled: outputs parked low, a load takes effect at once.
          tick[c]      <= 1'b0;
          sq[c]        <= 1'b0;
          pending_q[c] <= 1'b0;
          if (ld_sel[c]) begin
            div_q[c]    <= div_val;
            shadow_q[c] <= div_val;
            cnt_q[c]    <= div_val;
          end else begin
            cnt_q[c] <= '0;
          end
        end else begin
          // Running: loads are parked in the shadow until terminal count.
          if (ld_sel[c]) begin
            shadow_q[c]  <= div_val;
            pending_q[c] <= 1'b1;
          end
          if (!en) begin
            tick[c] <= 1'b0;
          end else if (cnt_q[c] != '0) begin
            cnt_q[c] <= cnt_q[c] - ONE;
            tick[c]  <= 1'b0;
          end else begin
            tick[c] <= 1'b1;
            sq[c]   <= ~sq[c];
            // A load landing on the terminal cycle is the reload value itself.
            if (ld_sel[c]) begin
              div_q[c]     <= div_val;
              cnt_q[c]     <= div_val;
              pending_q[c] <= 1'b0;
            end else if (pending_q[c]) begin
              div_q[c]     <= shadow_q[c];
              cnt_q[c]     <= shadow_q[c];
              pending_q[c] <= 1'b0;
            end else begin
              cnt_q[c] <= div_q[c];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Directed testbench for clk_tick_gen. Instance a: WIDTH=30, NUM_CH=4,
// DEFAULT_DIV=0. Instance b: WIDTH=4, NUM_CH=3, DEFAULT_DIV=2 (wrap,
// out-of-range channel, restart from a non-zero default).
module tb_clk_tick_gen;

  logic        clk = 1'b0;
  logic        reset;

  logic        en_a, ld_a;
  logic [1:0]  ch_a;
  logic [29:0] val_a;
  logic        ack_a;
  logic [29:0] free_a;
  logic [3:0]  tick_a, sq_a;

  logic        en_b, ld_b;
  logic [1:0]  ch_b;
  logic [3:0]  val_b;
  logic        ack_b;
  logic [3:0]  free_b;
  logic [2:0]  tick_b, sq_b;

  int checks = 0;
  int errors = 0;

  clk_tick_gen #(.WIDTH(30), .NUM_CH(4), .DEFAULT_DIV(0)) u_a (
    .clk(clk), .reset(reset), .en(en_a), .div_load(ld_a), .div_ch(ch_a),
    .div_val(val_a), .load_ack(ack_a), .free_cnt(free_a), .tick(tick_a), .sq(sq_a)
  );

  clk_tick_gen #(.WIDTH(4), .NUM_CH(3), .DEFAULT_DIV(2)) u_b (
    .clk(clk), .reset(reset), .en(en_b), .div_load(ld_b), .div_ch(ch_b),
    .div_val(val_b), .load_ack(ack_b), .free_cnt(free_b), .tick(tick_b), .sq(sq_b)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    en_a  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      checks++;
      if (free_a !== 30'd0 || tick_a !== 4'd0 || sq_a !== 4'd0 || ack_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_a free=%0d tick=%b sq=%b ack=%b expected 0", free_a, tick_a, sq_a, ack_a);
      end
      checks++;
      if (free_b !== 4'd0 || tick_b !== 3'd0 || sq_b !== 3'd0) begin
        errors++;
        $display("FAIL reset_b free=%0d tick=%b sq=%b expected 0", free_b, tick_b, sq_b);
      end
    end
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      checks++;
      if (free_a !== 30'(k)) begin
        errors++;
        $display("FAIL free_count got %0d expected %0d", free_a, k);
      end
      checks++;
      if (tick_a !== 4'd0 || sq_a !== 4'd0) begin
        errors++;
        $display("FAIL idle_outputs tick=%b sq=%b expected 0000", tick_a, sq_a);
      end
    end
  endtask

  task automatic test_period;
    logic et, es;
    int   n;
    ld_a = 1'b1; ch_a = 2'd0; val_a = 30'd4;
    cyc(1);
    ld_a = 1'b0;
    checks++;
    if (ack_a !== 1'b1) begin
      errors++;
      $display("FAIL period_ack got %b expected 1", ack_a);
    end
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      et = (k % 5 == 0);
      es = ((k / 5) % 2 == 1);
      checks++;
      if (tick_a[0] !== et || sq_a[0] !== es) begin
        errors++;
        $display("FAIL period4 k=%0d tick=%b sq=%b expected tick=%b sq=%b", k, tick_a[0], sq_a[0], et, es);
      end
      if (k == 1) begin
        checks++;
        if (ack_a !== 1'b0) begin
          errors++;
          $display("FAIL ack_pulse got %b expected 0", ack_a);
        end
      end
    end
    // Switch to N=1 while running: the current 5-cycle period finishes first.
    ld_a = 1'b1; ch_a = 2'd0; val_a = 30'd1;
    for (int m = 1; m <= 12; m++) begin
      cyc(1);
      ld_a = 1'b0;
      n  = (m >= 5) ? ((m - 5) / 2 + 1) : 0;
      et = (m >= 5) && (m % 2 == 1);
      es = (n % 2 == 1);
      checks++;
      if (tick_a[0] !== et || sq_a[0] !== es) begin
        errors++;
        $display("FAIL period1 m=%0d tick=%b sq=%b expected tick=%b sq=%b", m, tick_a[0], sq_a[0], et, es);
      end
    end
  endtask

  task automatic test_reload;
    logic et;
    ld_a = 1'b1; ch_a = 2'd1; val_a = 30'd9;
    cyc(1);
    ld_a = 1'b0;
    checks++;
    if (ack_a !== 1'b1) begin
      errors++;
      $display("FAIL reload_ack got %b expected 1", ack_a);
    end
    for (int k = 1; k <= 30; k++) begin
      if (k == 14) begin
        ld_a = 1'b1; ch_a = 2'd1; val_a = 30'd2;
      end
      cyc(1);
      ld_a = 1'b0;
      et = (k == 10) || (k == 20) || (k == 23) || (k == 26) || (k == 29);
      checks++;
      if (tick_a[1] !== et) begin
        errors++;
        $display("FAIL glitch_free k=%0d tick=%b expected %b", k, tick_a[1], et);
      end
    end
  endtask

  task automatic test_simultaneous;
    logic et;
    ld_a = 1'b1; ch_a = 2'd2; val_a = 30'd3;
    cyc(1);
    ld_a = 1'b0;
    for (int k = 1; k <= 23; k++) begin
      if (k == 8) begin
        ld_a = 1'b1; ch_a = 2'd2; val_a = 30'd6;
      end
      cyc(1);
      ld_a = 1'b0;
      et = (k == 4) || (k == 8) || (k == 15) || (k == 22);
      checks++;
      if (tick_a[2] !== et) begin
        errors++;
        $display("FAIL simul_load k=%0d tick=%b expected %b", k, tick_a[2], et);
      end
    end
  endtask

  task automatic test_boundaries;
    logic [2:0] et3, es3;
    logic       et, e1, s1, s0;
    en_b = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      cyc(1);
      et3 = (k % 3 == 0) ? 3'b111 : 3'b000;
      es3 = (((k / 3) % 2) == 1) ? 3'b111 : 3'b000;
      checks++;
      if (free_b !== 4'(k % 16)) begin
        errors++;
        $display("FAIL wrap k=%0d free=%0d expected %0d", k, free_b, k % 16);
      end
      checks++;
      if (tick_b !== et3 || sq_b !== es3) begin
        errors++;
        $display("FAIL default_div k=%0d tick=%b sq=%b expected tick=%b sq=%b", k, tick_b, sq_b, et3, es3);
      end
    end
    en_b = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cyc(1);
      checks++;
      if (free_b !== 4'd5 || tick_b !== 3'b000 || sq_b !== 3'b111) begin
        errors++;
        $display("FAIL en_freeze i=%0d free=%0d tick=%b sq=%b expected 5 000 111", i, free_b, tick_b, sq_b);
      end
    end
    en_b = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      if (j == 4) begin
        ld_b = 1'b1; ch_b = 2'd1; val_b = 4'd0;
      end
      if (j == 8) begin
        ld_b = 1'b1; ch_b = 2'd3; val_b = 4'd1;
      end
      cyc(1);
      ld_b = 1'b0;
      et = (j % 3 == 0);
      e1 = et && (j <= 6);
      s1 = (j < 3) || (j == 6);
      s0 = (((7 + j / 3) % 2) == 1);
      checks++;
      if (free_b !== 4'(5 + j)) begin
        errors++;
        $display("FAIL resume_free j=%0d free=%0d expected %0d", j, free_b, (5 + j) % 16);
      end
      checks++;
      if (tick_b[0] !== et || tick_b[2] !== et || sq_b[0] !== s0) begin
        errors++;
        $display("FAIL other_ch j=%0d tick=%b sq0=%b expected t0=t2=%b sq0=%b", j, tick_b, sq_b[0], et, s0);
      end
      checks++;
      if (tick_b[1] !== e1 || sq_b[1] !== s1) begin
        errors++;
        $display("FAIL div_zero j=%0d tick1=%b sq1=%b expected %b %b", j, tick_b[1], sq_b[1], e1, s1);
      end
      if (j == 4 || j == 8) begin
        checks++;
        if (ack_b !== (j == 4)) begin
          errors++;
          $display("FAIL ack_range j=%0d ack=%b expected %b", j, ack_b, (j == 4));
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic et;
    ld_a = 1'b1; ch_a = 2'd3; val_a = 30'd5;
    cyc(1);
    ld_a = 1'b0;
    cyc(3);
    ld_a = 1'b1; ch_a = 2'd3; val_a = 30'd2;
    ld_b = 1'b1; ch_b = 2'd0; val_b = 4'd7;
    cyc(1);
    ld_a = 1'b0;
    ld_b = 1'b0;
    reset = 1'b0;
    cyc(1);
    checks++;
    if (free_a !== 30'd0 || tick_a !== 4'd0 || sq_a !== 4'd0 || ack_a !== 1'b0) begin
      errors++;
      $display("FAIL midreset_a free=%0d tick=%b sq=%b ack=%b expected 0", free_a, tick_a, sq_a, ack_a);
    end
    checks++;
    if (free_b !== 4'd0 || tick_b !== 3'd0 || sq_b !== 3'd0 || ack_b !== 1'b0) begin
      errors++;
      $display("FAIL midreset_b free=%0d tick=%b sq=%b ack=%b expected 0", free_b, tick_b, sq_b, ack_b);
    end
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      et = (k % 3 == 0);
      checks++;
      if (free_a !== 30'(k) || tick_a !== 4'd0 || sq_a !== 4'd0) begin
        errors++;
        $display("FAIL restart_a k=%0d free=%0d tick=%b sq=%b expected %0d 0000 0000", k, free_a, tick_a, sq_a, k);
      end
      checks++;
      if (tick_b[0] !== et) begin
        errors++;
        $display("FAIL restart_b k=%0d tick0=%b expected %b", k, tick_b[0], et);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    en_a = 1'b0; ld_a = 1'b0; ch_a = 2'd0; val_a = 30'd0;
    en_b = 1'b0; ld_b = 1'b0; ch_b = 2'd0; val_b = 4'd0;
    test_reset;
    test_period;
    test_reload;
    test_simultaneous;
    test_boundaries;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
